// File: rtl/usb_data_buffer.sv
// usb_data_buffer
// 64-byte shared byte FIFO between the AHB-Lite slave and the USB RX/TX
// packet engines. Either side may push or pop; both pop strobes consume the
// same head byte, and both head outputs show that byte with no read latency.
//
// Optional build macro: USB_BUFFER_ERR_EN
//   When defined, sticky 'overflow' and 'underflow' status outputs are added.
//   When undefined, dropped pushes and ignored pops are silent.

module usb_data_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       flush,
    input  logic       store_tx_data,
    input  logic [7:0] tx_data,
    input  logic       get_rx_data,
    output logic [7:0] rx_data,
    input  logic       store_rx_packet_data,
    input  logic [7:0] rx_packet_data,
    input  logic       get_tx_packet_data,
    output logic [7:0] tx_packet_data,
    output logic [6:0] buffer_occ
`ifdef USB_BUFFER_ERR_EN
    ,
    output logic       overflow,
    output logic       underflow
`endif
);

    // Count value that means every slot holds a byte.
    localparam logic [6:0]        FULL_COUNT = 7'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [6:0]        occ;

    logic       kill;
    logic       push_req;
    logic       pop_req;
    logic [7:0] push_data;
    logic       pop_eff;
    logic       push_eff;
    logic       is_empty;
    logic       is_full;

    // Decide which push and pop requests actually take effect this cycle.
    always_comb begin
        kill      = 1'b0;
        push_req  = 1'b0;
        pop_req   = 1'b0;
        push_data = 8'h00;
        pop_eff   = 1'b0;
        push_eff  = 1'b0;
        is_empty  = 1'b0;
        is_full   = 1'b0;

        kill      = clear | flush;
        is_empty  = (occ == 7'd0);
        is_full   = (occ == FULL_COUNT);
        push_req  = store_tx_data | store_rx_packet_data;
        pop_req   = get_rx_data | get_tx_packet_data;
        // The AHB byte wins a collision; the RX byte is the one dropped.
        push_data = store_tx_data ? tx_data : rx_packet_data;
        // A pop on an empty buffer has nothing to consume.
        pop_eff   = pop_req && !is_empty && !kill;
        // When full, a same-cycle pop frees the slot the push needs.
        push_eff  = push_req && !kill && (!is_full || pop_eff);
    end

    // Pointer and occupancy registers; clear/flush override any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= 7'd0;
        end else if (kill) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= 7'd0;
        end else begin
            if (push_eff) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop_eff) begin
                rptr <= rptr + PTR_ONE;
            end
            if (push_eff && !pop_eff) begin
                occ <= occ + 7'd1;
            end else if (pop_eff && !push_eff) begin
                occ <= occ - 7'd1;
            end
        end
    end

    // Byte storage; contents survive clear/flush and are hidden while empty.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wptr] <= push_data;
        end
    end

    // First-word fall-through head byte, forced to zero when empty.
    always_comb begin
        rx_data        = 8'h00;
        tx_packet_data = 8'h00;
        if (!is_empty) begin
            rx_data        = mem[rptr];
            tx_packet_data = mem[rptr];
        end
    end

    assign buffer_occ = occ;

`ifdef USB_BUFFER_ERR_EN
    logic drop_push;
    logic empty_pop;

    // Classify lost operations that the status flags must record.
    always_comb begin
        drop_push = 1'b0;
        empty_pop = 1'b0;
        drop_push = (push_req && !push_eff) ||
                    (store_tx_data && store_rx_packet_data);
        empty_pop = pop_req && is_empty && !push_req;
    end

    // Sticky error flags, released only by clear, flush or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (kill) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | drop_push;
            underflow <= underflow | empty_pop;
        end
    end
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// tb_usb_data_buffer
// Directed bench for usb_data_buffer: a table of single-cycle vectors with
// hand-computed occupancy/head/flag values, followed by hand-written
// sequences for fill-to-full, drop-when-full, pointer wrap and async reset.
// Define USB_BUFFER_ERR_EN for both files to also check the sticky flags.

module tb_usb_data_buffer;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       flush;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_rx_data;
    logic [7:0] rx_data;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic       get_tx_packet_data;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occ;
`ifdef USB_BUFFER_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    int n_vec = 0;
    int n_err = 0;

    usb_data_buffer #(
        .DEPTH (64),
        .ADDR_W(6)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .clear               (clear),
        .flush               (flush),
        .store_tx_data       (store_tx_data),
        .tx_data             (tx_data),
        .get_rx_data         (get_rx_data),
        .rx_data             (rx_data),
        .store_rx_packet_data(store_rx_packet_data),
        .rx_packet_data      (rx_packet_data),
        .get_tx_packet_data  (get_tx_packet_data),
        .tx_packet_data      (tx_packet_data),
        .buffer_occ          (buffer_occ)
`ifdef USB_BUFFER_ERR_EN
        ,
        .overflow            (overflow),
        .underflow           (underflow)
`endif
    );

    // 10 ns free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       clr;
        logic       fl;
        logic       stx;
        logic [7:0] txd;
        logic       grx;
        logic       srx;
        logic [7:0] rxd;
        logic       gtx;
        logic [6:0] occ;
        logic [7:0] head;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic clr, input logic fl, input logic stx,
                                input logic [7:0] txd, input logic grx,
                                input logic srx, input logic [7:0] rxd,
                                input logic gtx, input logic [6:0] occ,
                                input logic [7:0] head, input logic ovf,
                                input logic unf);
        vec_t v;
        v.clr = clr; v.fl = fl; v.stx = stx; v.txd = txd; v.grx = grx;
        v.srx = srx; v.rxd = rxd; v.gtx = gtx; v.occ = occ; v.head = head;
        v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        clear = 1'b0; flush = 1'b0; store_tx_data = 1'b0; tx_data = 8'h00;
        get_rx_data = 1'b0; store_rx_packet_data = 1'b0;
        rx_packet_data = 8'h00; get_tx_packet_data = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        clear = v.clr; flush = v.fl; store_tx_data = v.stx; tx_data = v.txd;
        get_rx_data = v.grx; store_rx_packet_data = v.srx;
        rx_packet_data = v.rxd; get_tx_packet_data = v.gtx;
        step();
    endtask

    task automatic checkState(input string name, input logic [6:0] occ,
                              input logic [7:0] head);
        checkOutput({name, ".occ"}, {1'b0, buffer_occ}, {1'b0, occ});
        checkOutput({name, ".rx_data"}, rx_data, head);
        checkOutput({name, ".tx_pkt"}, tx_packet_data, head);
    endtask

    task automatic checkFlags(input string name, input logic ovf, input logic unf);
`ifdef USB_BUFFER_ERR_EN
        checkOutput({name, ".ovf"}, {7'd0, overflow}, {7'd0, ovf});
        checkOutput({name, ".unf"}, {7'd0, underflow}, {7'd0, unf});
`else
        if (ovf === 1'bx || unf === 1'bx) begin
            $display("[TB] flag expectation undefined in %s", name);
        end
`endif
    endtask

    task automatic pushTx(input logic [7:0] d);
        store_tx_data = 1'b1;
        tx_data       = d;
        step();
        store_tx_data = 1'b0;
    endtask

    // Head must hold the expected byte before the popping edge.
    task automatic popCheck(input string name, input logic [7:0] d);
        checkOutput(name, tx_packet_data, d);
        get_tx_packet_data = 1'b1;
        step();
        get_tx_packet_data = 1'b0;
    endtask

    task automatic doClear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        idleInputs();
        rst = 1'b1;
        #12;
        checkState("reset", 7'd0, 8'h00);
        checkFlags("reset", 1'b0, 1'b0);
        rst = 1'b0;

        //            clr   fl    stx   txd    grx   srx   rxd    gtx   occ    head   ovf   unf
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 7'd1, 8'hA5, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0, 7'd2, 8'hA5, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 7'd1, 8'h11, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b1, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 7'd1, 8'h3C, 1'b1, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 7'd1, 8'h55, 1'b1, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 7'd0, 8'h00, 1'b1, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 7'd1, 8'h77, 1'b1, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h88, 1'b0, 7'd2, 8'h77, 1'b1, 1'b1);
        vecs[11] = mk(1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 7'd1, 8'h12, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h34, 1'b1, 7'd0, 8'h00, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            checkState($sformatf("vec%0d", i), vecs[i].occ, vecs[i].head);
            checkFlags($sformatf("vec%0d", i), vecs[i].ovf, vecs[i].unf);
        end
        idleInputs();

        // Fill to 64, drop a 65th push, then drain in order.
        doClear();
        for (int i = 0; i < 64; i++) pushTx(8'(i));
        checkState("full", 7'd64, 8'h00);
        checkFlags("full", 1'b0, 1'b0);
        pushTx(8'hFF);
        checkState("full_drop", 7'd64, 8'h00);
        checkFlags("full_drop", 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) popCheck($sformatf("drain%0d", i), 8'(i));
        checkState("drained", 7'd0, 8'h00);

        // Push+pop while full keeps 64 and the new byte leaves last.
        doClear();
        for (int i = 0; i < 64; i++) pushTx(8'(i));
        store_tx_data = 1'b1; tx_data = 8'hEE; get_tx_packet_data = 1'b1;
        step();
        idleInputs();
        checkState("full_pp", 7'd64, 8'h01);
        for (int i = 1; i < 64; i++) popCheck($sformatf("fpp%0d", i), 8'(i));
        popCheck("fpp_last", 8'hEE);
        checkState("fpp_empty", 7'd0, 8'h00);

        // Pointer wrap: 40 in/out, then 40 more crossing slot 63.
        doClear();
        for (int i = 0; i < 40; i++) pushTx(8'h40 + 8'(i));
        for (int i = 0; i < 40; i++) popCheck($sformatf("wa%0d", i), 8'h40 + 8'(i));
        for (int i = 0; i < 40; i++) pushTx(8'hC0 + 8'(i));
        checkState("wrap_fill", 7'd40, 8'hC0);
        for (int i = 0; i < 40; i++) popCheck($sformatf("wb%0d", i), 8'hC0 + 8'(i));
        checkState("wrap_empty", 7'd0, 8'h00);

        // Asynchronous reset mid-transfer clears state without a clock edge.
        for (int i = 0; i < 5; i++) pushTx(8'h60 + 8'(i));
        store_tx_data = 1'b1; tx_data = 8'hAB;
        #2;
        rst = 1'b1;
        #1;
        checkState("async_rst", 7'd0, 8'h00);
        step();
        checkState("rst_hold", 7'd0, 8'h00);
        idleInputs();
        rst = 1'b0;
        step();
        checkState("post_rst", 7'd0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
